nlfsr_search_core: RTL and testbench



---
 rtl/nlfsr_search_core.sv | 207 ++++++++++++++++++++
 tb/tb_nlfsr_search_core.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/nlfsr_search_core.sv
// nlfsr_search_core: draws random tap indices from an internal PRNG, builds a
// nonlinear feedback shift register from them and steps it from state 1 until
// the period is classified as maximal (found) or not (failure).
module nlfsr_search_core #(
  parameter int          NUM_OF_TAPS = 16,
  parameter int          SIZE        = 32,
  parameter logic [31:0] SEED        = 32'd13413515
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     ena,
  output logic [NUM_OF_TAPS*8-1:0] taps,
  output logic                     selector_done,
  output logic [SIZE-1:0]          state,
  output logic                     found,
  output logic                     failure
);

  localparam int              IDX_W      = $clog2(SIZE);
  localparam int              SLOT_W     = $clog2(NUM_OF_TAPS + 1);
  localparam int              HALF       = NUM_OF_TAPS / 2;
  localparam int              PAIRS      = HALF / 2;
  localparam logic [31:0]     PRNG_MASK  = 32'h80200003;
  localparam logic [SIZE-1:0] STATE_ONE  = {{(SIZE-1){1'b0}}, 1'b1};
  localparam logic [SIZE-1:0] MAX_PERIOD = '1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_OF_TAPS);

  typedef enum logic [1:0] {
    S_SELECT,
    S_RUN,
    S_HOLD
  } ctrl_t;

  // ---------------------------------------------------------------- PRNG
  // The LFSR is loaded with SEED at configuration only; res never reloads
  // it, so every new attempt sees fresh bytes.
  logic [31:0] prng_reg = SEED;
  logic [31:0] prng_next;
  logic [2:0]  phase_reg;
  logic        prng_done;
  logic [7:0]  prng_byte;

  // Galois step: shift right, fold the mask in when a one falls out.
  always_comb begin
    prng_next = prng_reg >> 1;
    if (prng_reg[0]) begin
      prng_next = (prng_reg >> 1) ^ PRNG_MASK;
    end
  end

  // PRNG free-runs every cycle, independent of res and ena.
  always_ff @(posedge clk) begin
    prng_reg <= prng_next;
  end

  // Phase counter marks every eighth cycle as a byte-ready strobe.
  always_ff @(posedge clk) begin
    if (res) begin
      phase_reg <= 3'd0;
    end else begin
      phase_reg <= phase_reg + 3'd1;
    end
  end

  assign prng_done = (phase_reg == 3'd7);
  assign prng_byte = prng_reg[7:0];

  // ------------------------------------------------------------ selector
  logic [7:0]             taps_reg [NUM_OF_TAPS];
  logic [SLOT_W-1:0]      slot_reg;
  logic [7:0]             cand;
  logic [NUM_OF_TAPS-1:0] tap_match;
  logic                   cand_ok;
  logic                   store;
  ctrl_t                  fsm_reg;
  ctrl_t                  fsm_next;

  assign cand = 8'(({8'd0, prng_byte}) % 16'(SIZE));

  // Unfilled slots hold 0 and a candidate of 0 is rejected anyway, so the
  // duplicate test can safely look at every slot.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_OF_TAPS; gi++) begin : g_match
      assign tap_match[gi]       = (taps_reg[gi] == cand);
      assign taps[8*gi +: 8]     = taps_reg[gi];
    end
  endgenerate

  assign cand_ok = prng_done && (cand != 8'd0) && !(|tap_match);
  assign store   = ena && (fsm_reg == S_SELECT) && (slot_reg != LAST_SLOT) && cand_ok;

  // Accepted candidates fill the slots in order.
  always_ff @(posedge clk) begin
    if (res) begin
      for (int k = 0; k < NUM_OF_TAPS; k++) begin
        taps_reg[k] <= 8'd0;
      end
      slot_reg <= '0;
    end else if (store) begin
      for (int k = 0; k < NUM_OF_TAPS; k++) begin
        if (slot_reg == SLOT_W'(k)) begin
          taps_reg[k] <= cand;
        end
      end
      slot_reg <= slot_reg + SLOT_W'(1);
    end
  end

  // ------------------------------------------------------------ feedback
  logic [SIZE-1:0]        state_reg;
  logic [SIZE-1:0]        state_step;
  logic [NUM_OF_TAPS-1:0] tap_bit;
  logic [PAIRS-1:0]       and_term;
  logic                   fb;

  generate
    for (gi = 0; gi < NUM_OF_TAPS; gi++) begin : g_tap_bit
      assign tap_bit[gi] = state_reg[taps_reg[gi][IDX_W-1:0]];
    end
    for (gi = 0; gi < PAIRS; gi++) begin : g_pair
      assign and_term[gi] = tap_bit[HALF + 2*gi] & tap_bit[HALF + 2*gi + 1];
    end
  endgenerate

  // Taps are never 0, so state[0] enters the feedback exactly once and the
  // map stays a permutation; state 1 is therefore always revisited.
  assign fb         = state_reg[0] ^ (^tap_bit[HALF-1:0]) ^ (^and_term);
  assign state_step = {fb, state_reg[SIZE-1:1]};

  // ------------------------------------------------------------- control
  logic [SIZE-1:0] cnt_reg;
  logic            do_step;
  logic            hit_one;
  logic            is_max;
  logic            found_reg;
  logic            failure_reg;

  // Control state register.
  always_ff @(posedge clk) begin
    if (res) begin
      fsm_reg <= S_SELECT;
    end else begin
      fsm_reg <= fsm_next;
    end
  end

  // Next-state: select taps, step until state returns to 1, then hold.
  always_comb begin
    fsm_next = fsm_reg;
    do_step  = 1'b0;
    case (fsm_reg)
      S_SELECT: begin
        if (ena && (slot_reg == LAST_SLOT)) begin
          fsm_next = S_RUN;
        end
      end
      S_RUN: begin
        if (ena) begin
          do_step = 1'b1;
          if (state_step == STATE_ONE) begin
            fsm_next = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        fsm_next = S_HOLD;
      end
      default: begin
        fsm_next = S_SELECT;
      end
    endcase
  end

  assign hit_one = do_step && (state_step == STATE_ONE);
  assign is_max  = ((cnt_reg + STATE_ONE) == MAX_PERIOD);

  // NLFSR register and step counter advance together.
  always_ff @(posedge clk) begin
    if (res) begin
      state_reg <= STATE_ONE;
      cnt_reg   <= '0;
    end else if (do_step) begin
      state_reg <= state_step;
      cnt_reg   <= cnt_reg + STATE_ONE;
    end
  end

  // Outcome flags: found is sticky, failure lasts a single cycle.
  always_ff @(posedge clk) begin
    if (res) begin
      found_reg   <= 1'b0;
      failure_reg <= 1'b0;
    end else begin
      failure_reg <= hit_one && !is_max;
      if (hit_one && is_max) begin
        found_reg <= 1'b1;
      end
    end
  end

  assign selector_done = (fsm_reg != S_SELECT);
  assign state         = state_reg;
  assign found         = found_reg;
  assign failure       = failure_reg;

endmodule

// File: tb/tb_nlfsr_search_core.sv
// Scoreboard bench for nlfsr_search_core (SIZE=5, NUM_OF_TAPS=4): a driver
// issues res/ena per cycle, a reference model predicts the visible outputs,
// and a monitor on the falling edge pops and compares.
module tb_nlfsr_search_core;

  localparam int          NT   = 4;
  localparam int          SZ   = 5;
  localparam int          MAXP = 31;
  localparam logic [31:0] SEED = 32'd13413515;
  localparam logic [31:0] MASK = 32'h80200003;

  logic          clk;
  logic          res;
  logic          ena;
  logic [NT*8-1:0] taps;
  logic          selector_done;
  logic [SZ-1:0] state;
  logic          found;
  logic          failure;

  nlfsr_search_core #(
    .NUM_OF_TAPS(NT),
    .SIZE(SZ),
    .SEED(SEED)
  ) dut (
    .clk(clk),
    .res(res),
    .ena(ena),
    .taps(taps),
    .selector_done(selector_done),
    .state(state),
    .found(found),
    .failure(failure)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [NT*8-1:0] taps;
    logic            sd;
    logic [SZ-1:0]   st;
    logic            fd;
    logic            fl;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  logic [31:0]   m_lfsr = SEED;
  int            m_sr = 0;
  int            m_taps[$];
  bit            m_sel_done = 0;
  logic [SZ-1:0] m_state = 1;
  int            m_cnt = 0;
  bit            m_found = 0;
  bit            m_failure = 0;
  bit            m_halt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [SZ-1:0] nl_next(input logic [SZ-1:0] s);
    logic f;
    f = s[0];
    for (int i = 0; i < NT/2; i++) f = f ^ s[m_taps[i]];
    for (int j = NT/2; j < NT; j += 2) f = f ^ (s[m_taps[j]] & s[m_taps[j+1]]);
    return {f, s[SZ-1:1]};
  endfunction

  function automatic logic [NT*8-1:0] pack_taps();
    logic [NT*8-1:0] v;
    v = '0;
    for (int k = 0; k < NT; k++) begin
      if (k < m_taps.size()) v[8*k +: 8] = 8'(m_taps[k]);
    end
    return v;
  endfunction

  // Advance the model across one rising edge and queue what should be seen.
  task automatic model_step(input bit r, input bit e);
    bit   done;
    bit   dup;
    int   t;
    exp_t x;
    done   = ((m_sr % 8) == 7);
    t      = int'(m_lfsr[7:0]) % SZ;
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ MASK) : (m_lfsr >> 1);
    if (r) begin
      m_taps.delete();
      m_sel_done = 0; m_state = 1; m_cnt = 0;
      m_found = 0; m_failure = 0; m_halt = 0; m_sr = 0;
    end else begin
      m_sr++;
      m_failure = 0;
      if (e && !m_sel_done) begin
        if (m_taps.size() == NT) begin
          m_sel_done = 1;
        end else if (done && t != 0) begin
          dup = 0;
          foreach (m_taps[i]) if (m_taps[i] == t) dup = 1;
          if (!dup) m_taps.push_back(t);
        end
      end else if (e && !m_halt) begin
        m_state = nl_next(m_state);
        m_cnt++;
        if (m_state == 1) begin
          m_halt = 1;
          if (m_cnt == MAXP) m_found = 1;
          else m_failure = 1;
        end
      end
    end
    x.taps = pack_taps();
    x.sd   = m_sel_done;
    x.st   = m_state;
    x.fd   = m_found;
    x.fl   = m_failure;
    q.push_back(x);
  endtask

  task automatic cyc(input bit r, input bit e);
    res = r;
    ena = e;
    model_step(r, e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each cycle's outputs against the oldest expectation.
  initial begin
    exp_t x;
    bit   prev_sd;
    bit   ok;
    logic [7:0] a;
    logic [7:0] b;
    prev_sd = 0;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("taps", 32'(taps), 32'(x.taps));
        chk("selector_done", 32'(selector_done), 32'(x.sd));
        chk("state", 32'(state), 32'(x.st));
        chk("found", 32'(found), 32'(x.fd));
        chk("failure", 32'(failure), 32'(x.fl));
        if (selector_done === 1'b1 && !prev_sd) begin
          ok = 1;
          for (int k = 0; k < NT; k++) begin
            a = taps[8*k +: 8];
            if (a == 0 || a >= SZ) ok = 0;
            for (int j = 0; j < k; j++) begin
              b = taps[8*j +: 8];
              if (a == b) ok = 0;
            end
          end
          chk("taps_distinct_in_range", 32'(ok), 32'd1);
        end
        prev_sd = (selector_done === 1'b1);
      end
    end
  end

  // Driver: idle check, then repeated attempts until found.
  initial begin
    bit drop_sel;
    bit drop_step;
    bit collided;
    bit aborted;
    int budget;
    drop_sel = 0; drop_step = 0; collided = 0;
    res = 1'b1; ena = 1'b0;
    repeat (3) cyc(1, 0);
    repeat (50) cyc(0, 0);
    $display("idle: 50 cycles with ena low");

    for (int att = 0; att < 30 && !m_found; att++) begin
      cyc(1, 0);
      aborted = 0;
      budget  = 0;
      while (!m_halt && budget < 3000) begin
        budget++;
        if (!drop_sel && !m_sel_done && m_taps.size() == 2) begin
          repeat (20) cyc(0, 0);
          drop_sel = 1;
        end
        if (!drop_step && m_sel_done && !m_halt && m_cnt == 3) begin
          repeat (20) cyc(0, 0);
          drop_step = 1;
        end
        if (att >= 1 && !collided && m_sel_done && !m_halt && nl_next(m_state) == 1) begin
          cyc(1, 1);
          collided = 1;
          aborted  = 1;
          break;
        end
        cyc(0, ($urandom_range(0, 7) != 0));
      end
      if (!aborted && !m_halt) begin
        checks++;
        errors++;
        $display("FAIL attempt_budget: attempt %0d got no outcome within 3000 cycles, required found or failure", att);
        break;
      end
      if (!aborted) repeat (2) cyc(0, 1);
      $display("attempt %0d: taps=%h steps=%0d outcome=%s", att, pack_taps(), m_cnt,
               aborted ? "aborted by res" : (m_found ? "found" : "failure"));
    end

    if (m_found) repeat (20) cyc(0, ($urandom_range(0, 1) != 0));

    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
